dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
// Data-memory access stage sitting directly upstream of the load unit. Accepts one
// load/store request at a time from execute, validates alignment, generates byte
// enables and lane-replicated store data, and drives a req/gnt/rvalid memory port.
// Registers the raw 32-bit load word with addr[1:0]/funct3 so the load unit can
// extract and extend it. Timeouts and misalignment are reported as errors.
// PARAMETERS
// ADDR_WIDTH      12  word-address width driven on o_mem_addr (byte addr [ADDR_WIDTH+1:2])
// TIMEOUT_CYCLES  64  max cycles in REQ+WAIT before error; 0 disables timeout
// PORTS
// i_clk          in   1   clock, all state on rising edge
// i_rst_n        in   1   asynchronous active-low reset
// i_req_valid    in   1   request valid from execute
// o_req_ready    out  1   1 only in IDLE
// i_req_load     in   1   request is a load
// i_req_store    in   1   request is a store
// i_req_addr     in   32  byte address
// i_req_funct3   in   3   RV32I width code (000 B,001 H,010 W,100 BU,101 HU)
// i_req_wdata    in   32  store data (rs2)
// o_mem_req      out  1   memory request, held until i_mem_gnt
// o_mem_we       out  1   1 = write
// o_mem_addr     out  ADDR_WIDTH  word address
// o_mem_be       out  4   byte enables (writes only; 4'b0000 on reads)
// o_mem_wdata    out  32  lane-replicated store data
// i_mem_gnt      in   1   request accepted by memory
// i_mem_rvalid   in   1   read data valid (earliest one cycle after gnt)
// i_mem_rdata    in   32  read data word
// o_rsp_valid    out  1   response valid toward load unit/writeback
// i_rsp_ready    in   1   response consumed
// o_rsp_load     out  1   response belongs to a load (drives load unit i_load)
// o_rsp_addr     out  2   byte offset of request
// o_rsp_funct3   out  3   funct3 of request
// o_rsp_rdata    out  32  raw memory word (0 for stores and errors)
// o_rsp_err      out  1   misaligned, load&store both set, or timeout
// BEHAVIOUR
// - Reset: state=IDLE; o_req_ready=1; all other outputs 0; timeout counter 0.
// - FSM IDLE->REQ->(WAIT)->RSP->IDLE. All outputs registered/decoded from state regs.
// - IDLE: accept when i_req_valid; capture addr, funct3, load flag. Errors checked here:
//   H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0; load&store both 1 -> RSP, err=1,
//   no memory access. Neither load nor store -> RSP, err=0 (no-op). Else -> REQ.
// - REQ: o_mem_req=1, address/we/be/wdata stable until i_mem_gnt. On gnt: store -> RSP;
//   load -> WAIT.
// - WAIT: on i_mem_rvalid capture i_mem_rdata into o_rsp_rdata -> RSP.
// - RSP: o_rsp_valid=1, fields stable until i_rsp_ready; then IDLE (ready next cycle,
//   no back-to-back acceptance in the same cycle).
// - BE: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
// - wdata: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
// - Timeout: counter clears on entry to REQ, increments each cycle in REQ/WAIT; reaching
//   TIMEOUT_CYCLES -> RSP, err=1, rdata=0, o_mem_req drops. Late gnt/rvalid afterwards ignored.
// - i_mem_rvalid outside WAIT ignored; i_mem_gnt outside REQ ignored.
// - Best-case latency: load accept c0, req c1 (gnt), rvalid c2, o_rsp_valid c3;
//   store accept c0, gnt c1, o_rsp_valid c2.
// - Async reset mid-transaction: immediate return to IDLE, o_mem_req and o_rsp_valid drop.
// TESTING
// - LW addr 0x100, gnt c1, rvalid c2 rdata 0xDEADBEEF -> c3 rsp_valid, rdata 0xDEADBEEF, addr 0, err 0.
// - SB addr 0x103 wdata 0x000000A5 -> mem_be 4'b1000, mem_wdata 0xA5A5A5A5, mem_we 1, rsp err 0.
// - LH addr 0x101 -> no o_mem_req ever, rsp_valid next cycle with err 1, rdata 0.
// - gnt withheld 5 cycles, i_rsp_ready low 3 cycles -> addr/be stable in REQ, rsp fields stable.
// - TIMEOUT_CYCLES=4, no gnt -> o_mem_req for 4 cycles then rsp err 1; late rvalid ignored.
// - i_rst_n asserted in WAIT -> outputs 0, o_req_ready 1; next LW completes normally.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Data-memory access stage: validates alignment, builds byte enables and lane-replicated
// store data, runs a req/gnt/rvalid handshake and returns the raw word to the load unit.
module dmem_access_unit #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_load,
  input  logic                  i_req_store,
  input  logic [31:0]           i_req_addr,
  input  logic [2:0]            i_req_funct3,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [31:0]           o_mem_wdata,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [31:0]           i_mem_rdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_load,
  output logic [1:0]            o_rsp_addr,
  output logic [2:0]            o_rsp_funct3,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMAX  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wordAddr_q;
  logic [1:0]            offset_q;
  logic [2:0]            funct3_q;
  logic                  load_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic [CNT_W-1:0]      cnt_q;

  logic       misaligned;
  logic       timeoutHit;
  logic [3:0] beNext;
  logic [31:0] wdataNext;
  logic       unusedAddrBits;

  assign unusedAddrBits = ^i_req_addr[31:ADDR_WIDTH+2];

  // funct3[1:0] encodes access size for both loads and stores; size 2'b11 is treated as word
  always_comb begin
    beNext     = 4'b1111;
    wdataNext  = i_req_wdata;
    misaligned = 1'b0;
    case (i_req_funct3[1:0])
      2'b00: begin
        beNext    = 4'b0001 << i_req_addr[1:0];
        wdataNext = {4{i_req_wdata[7:0]}};
      end
      2'b01: begin
        beNext     = 4'b0011 << i_req_addr[1:0];
        wdataNext  = {2{i_req_wdata[15:0]}};
        misaligned = i_req_addr[0];
      end
      default: misaligned = (i_req_addr[1:0] != 2'b00);
    endcase
  end

  assign timeoutHit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_W'(TMAX));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      wordAddr_q <= '0;
      offset_q   <= '0;
      funct3_q   <= '0;
      load_q     <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            wordAddr_q <= i_req_addr[ADDR_WIDTH+1:2];
            offset_q   <= i_req_addr[1:0];
            funct3_q   <= i_req_funct3;
            load_q     <= i_req_load;
            we_q       <= i_req_store;
            be_q       <= i_req_store ? beNext : 4'b0000;
            wdata_q    <= i_req_store ? wdataNext : 32'h0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            if ((i_req_load && i_req_store) ||
                ((i_req_load || i_req_store) && misaligned)) begin
              err_q   <= 1'b1;
              state_q <= RSP;
            end else if (!i_req_load && !i_req_store) begin
              err_q   <= 1'b0;
              state_q <= RSP;
            end else begin
              err_q   <= 1'b0;
              state_q <= REQ;
            end
          end
        end
        // A load granted on the final budget cycle cannot return in time, so it times out
        REQ: begin
          if (i_mem_gnt && we_q) begin
            state_q <= RSP;
          end else if (timeoutHit) begin
            err_q   <= 1'b1;
            state_q <= RSP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (i_mem_gnt) state_q <= WAIT;
          end
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            rdata_q <= i_mem_rdata;
            state_q <= RSP;
          end else if (timeoutHit) begin
            err_q   <= 1'b1;
            state_q <= RSP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RSP: begin
          if (i_rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = (state_q == IDLE);
  assign o_mem_req    = (state_q == REQ);
  assign o_mem_we     = o_mem_req & we_q;
  assign o_mem_addr   = o_mem_req ? wordAddr_q : '0;
  assign o_mem_be     = o_mem_req ? be_q : 4'b0000;
  assign o_mem_wdata  = o_mem_req ? wdata_q : 32'h0;
  assign o_rsp_valid  = (state_q == RSP);
  assign o_rsp_load   = o_rsp_valid & load_q;
  assign o_rsp_addr   = o_rsp_valid ? offset_q : 2'b00;
  assign o_rsp_funct3 = o_rsp_valid ? funct3_q : 3'b000;
  assign o_rsp_rdata  = o_rsp_valid ? rdata_q : 32'h0;
  assign o_rsp_err    = o_rsp_valid & err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit; a second instance with a short
// timeout budget exercises the timeout path independently of the main instance.
module tb_dmem_access_unit;

  logic        clock;
  logic        rstN;
  logic        reqValid, reqLoad, reqStore;
  logic [31:0] reqAddr, reqWdata, memRdata;
  logic [2:0]  reqFunct3;
  logic        memGnt, memRvalid, rspReady;
  logic        reqReady, memReq, memWe, rspValid, rspLoad, rspErr;
  logic [11:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWdata, rspRdata;
  logic [1:0]  rspAddr;
  logic [2:0]  rspFunct3;

  logic        toReqValid, toGnt, toRvalid, toRspReady;
  logic        toReqReady, toMemReq, toMemWe, toRspValid, toRspLoad, toRspErr;
  logic [11:0] toMemAddr;
  logic [3:0]  toMemBe;
  logic [31:0] toMemWdata, toRspRdata;
  logic [1:0]  toRspAddr;
  logic [2:0]  toRspFunct3;

  int checkCount = 0;
  int passCount  = 0;

  dmem_access_unit dut (
    .i_clk(clock), .i_rst_n(rstN),
    .i_req_valid(reqValid), .o_req_ready(reqReady),
    .i_req_load(reqLoad), .i_req_store(reqStore),
    .i_req_addr(reqAddr), .i_req_funct3(reqFunct3), .i_req_wdata(reqWdata),
    .o_mem_req(memReq), .o_mem_we(memWe), .o_mem_addr(memAddr),
    .o_mem_be(memBe), .o_mem_wdata(memWdata),
    .i_mem_gnt(memGnt), .i_mem_rvalid(memRvalid), .i_mem_rdata(memRdata),
    .o_rsp_valid(rspValid), .i_rsp_ready(rspReady), .o_rsp_load(rspLoad),
    .o_rsp_addr(rspAddr), .o_rsp_funct3(rspFunct3),
    .o_rsp_rdata(rspRdata), .o_rsp_err(rspErr)
  );

  dmem_access_unit #(.ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) dutTo (
    .i_clk(clock), .i_rst_n(rstN),
    .i_req_valid(toReqValid), .o_req_ready(toReqReady),
    .i_req_load(reqLoad), .i_req_store(reqStore),
    .i_req_addr(reqAddr), .i_req_funct3(reqFunct3), .i_req_wdata(reqWdata),
    .o_mem_req(toMemReq), .o_mem_we(toMemWe), .o_mem_addr(toMemAddr),
    .o_mem_be(toMemBe), .o_mem_wdata(toMemWdata),
    .i_mem_gnt(toGnt), .i_mem_rvalid(toRvalid), .i_mem_rdata(memRdata),
    .o_rsp_valid(toRspValid), .i_rsp_ready(toRspReady), .o_rsp_load(toRspLoad),
    .o_rsp_addr(toRspAddr), .o_rsp_funct3(toRspFunct3),
    .o_rsp_rdata(toRspRdata), .o_rsp_err(toRspErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic ld, input logic st,
                               input logic [31:0] addr, input logic [2:0] f3,
                               input logic [31:0] wd);
    reqValid  = valid;
    reqLoad   = ld;
    reqStore  = st;
    reqAddr   = addr;
    reqFunct3 = f3;
    reqWdata  = wd;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Releases the response from the main instance and confirms it returns to IDLE
  task automatic finishRsp(input string tag);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkOutput({tag, "_idle_ready"}, 32'(reqReady), 32'd1);
    checkOutput({tag, "_idle_rspv"}, 32'(rspValid), 32'd0);
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    memGnt = 0; memRvalid = 0; memRdata = 32'h0; rspReady = 0;
    toReqValid = 0; toGnt = 0; toRvalid = 0; toRspReady = 0;
    #12;
    checkOutput("rst_ready", 32'(reqReady), 32'd1);
    checkOutput("rst_memreq", 32'(memReq), 32'd0);
    checkOutput("rst_rspvalid", 32'(rspValid), 32'd0);
    checkOutput("rst_be", 32'(memBe), 32'd0);
    rstN = 1'b1;
    tick();

    // LW 0x100: best-case load timing
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 3'b010, 32'h0);
    tick();
    reqValid = 1'b0;
    checkOutput("lw_memreq", 32'(memReq), 32'd1);
    checkOutput("lw_ready", 32'(reqReady), 32'd0);
    checkOutput("lw_addr", 32'(memAddr), 32'h40);
    checkOutput("lw_we", 32'(memWe), 32'd0);
    checkOutput("lw_be", 32'(memBe), 32'd0);
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0; memRvalid = 1'b1; memRdata = 32'hDEADBEEF;
    checkOutput("lw_wait_memreq", 32'(memReq), 32'd0);
    checkOutput("lw_wait_rspv", 32'(rspValid), 32'd0);
    tick();
    memRvalid = 1'b0;
    checkOutput("lw_rspv", 32'(rspValid), 32'd1);
    checkOutput("lw_rdata", rspRdata, 32'hDEADBEEF);
    checkOutput("lw_rspaddr", 32'(rspAddr), 32'd0);
    checkOutput("lw_err", 32'(rspErr), 32'd0);
    checkOutput("lw_load", 32'(rspLoad), 32'd1);
    checkOutput("lw_f3", 32'(rspFunct3), 32'd2);
    finishRsp("lw");

    // SB 0x103: top lane, replicated byte
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h103, 3'b000, 32'h000000A5);
    tick();
    reqValid = 1'b0;
    checkOutput("sb_be", 32'(memBe), 32'h8);
    checkOutput("sb_wdata", memWdata, 32'hA5A5A5A5);
    checkOutput("sb_we", 32'(memWe), 32'd1);
    checkOutput("sb_addr", 32'(memAddr), 32'h40);
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    checkOutput("sb_rspv", 32'(rspValid), 32'd1);
    checkOutput("sb_err", 32'(rspErr), 32'd0);
    checkOutput("sb_rdata", rspRdata, 32'h0);
    checkOutput("sb_load", 32'(rspLoad), 32'd0);
    checkOutput("sb_rspaddr", 32'(rspAddr), 32'd3);
    finishRsp("sb");

    // LH 0x101: misaligned, never reaches memory
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h101, 3'b001, 32'h0);
    tick();
    reqValid = 1'b0;
    checkOutput("lh_mis_memreq", 32'(memReq), 32'd0);
    checkOutput("lh_mis_rspv", 32'(rspValid), 32'd1);
    checkOutput("lh_mis_err", 32'(rspErr), 32'd1);
    checkOutput("lh_mis_rdata", rspRdata, 32'h0);
    finishRsp("lh_mis");

    // SW 0x102: misaligned word store
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h102, 3'b010, 32'h11223344);
    tick();
    reqValid = 1'b0;
    checkOutput("sw_mis_memreq", 32'(memReq), 32'd0);
    checkOutput("sw_mis_err", 32'(rspErr), 32'd1);
    finishRsp("sw_mis");

    // Load and store both set: error without access
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h10, 3'b010, 32'h0);
    tick();
    reqValid = 1'b0;
    checkOutput("both_memreq", 32'(memReq), 32'd0);
    checkOutput("both_err", 32'(rspErr), 32'd1);
    finishRsp("both");

    // Neither load nor store: no-op response
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h13, 3'b010, 32'h0);
    tick();
    reqValid = 1'b0;
    checkOutput("noop_memreq", 32'(memReq), 32'd0);
    checkOutput("noop_rspv", 32'(rspValid), 32'd1);
    checkOutput("noop_err", 32'(rspErr), 32'd0);
    finishRsp("noop");

    // SH 0x202 with gnt withheld 5 cycles and rsp_ready low 3 cycles
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h202, 3'b001, 32'h1234ABCD);
    tick();
    reqValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) memGnt = 1'b1;
      checkOutput($sformatf("sh_stall_req%0d", i), 32'(memReq), 32'd1);
      checkOutput($sformatf("sh_stall_be%0d", i), 32'(memBe), 32'hC);
      checkOutput($sformatf("sh_stall_addr%0d", i), 32'(memAddr), 32'h80);
      checkOutput($sformatf("sh_stall_wd%0d", i), memWdata, 32'hABCDABCD);
      tick();
    end
    memGnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("sh_hold_rspv%0d", i), 32'(rspValid), 32'd1);
      checkOutput($sformatf("sh_hold_addr%0d", i), 32'(rspAddr), 32'd2);
      checkOutput($sformatf("sh_hold_f3%0d", i), 32'(rspFunct3), 32'd1);
      checkOutput($sformatf("sh_hold_err%0d", i), 32'(rspErr), 32'd0);
      tick();
    end
    finishRsp("sh");

    // Timeout instance: 4 cycles of request, then error; late gnt/rvalid ignored
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 3'b010, 32'h0);
    toReqValid = 1'b1;
    tick();
    toReqValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("to_memreq%0d", i), 32'(toMemReq), 32'd1);
      tick();
    end
    checkOutput("to_memreq_drop", 32'(toMemReq), 32'd0);
    checkOutput("to_rspv", 32'(toRspValid), 32'd1);
    checkOutput("to_err", 32'(toRspErr), 32'd1);
    checkOutput("to_rdata", toRspRdata, 32'h0);
    toGnt = 1'b1; toRvalid = 1'b1; memRdata = 32'h12345678;
    tick();
    checkOutput("to_late_rdata", toRspRdata, 32'h0);
    checkOutput("to_late_err", 32'(toRspErr), 32'd1);
    toRspReady = 1'b1;
    tick();
    toRspReady = 1'b0; toGnt = 1'b0; toRvalid = 1'b0;
    checkOutput("to_idle_ready", 32'(toReqReady), 32'd1);
    checkOutput("to_idle_rspv", 32'(toRspValid), 32'd0);
    checkOutput("main_unaffected", 32'(reqReady), 32'd1);

    // Async reset while waiting for read data
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h104, 3'b010, 32'h0);
    tick();
    reqValid = 1'b0;
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    checkOutput("rstw_inwait_memreq", 32'(memReq), 32'd0);
    checkOutput("rstw_inwait_ready", 32'(reqReady), 32'd0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rstw_ready", 32'(reqReady), 32'd1);
    checkOutput("rstw_memreq", 32'(memReq), 32'd0);
    checkOutput("rstw_rspv", 32'(rspValid), 32'd0);
    #2;
    rstN = 1'b1;
    tick();

    // Normal LW after reset
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h108, 3'b010, 32'h0);
    tick();
    reqValid = 1'b0;
    checkOutput("lw2_addr", 32'(memAddr), 32'h42);
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0; memRvalid = 1'b1; memRdata = 32'hCAFEF00D;
    tick();
    memRvalid = 1'b0;
    checkOutput("lw2_rspv", 32'(rspValid), 32'd1);
    checkOutput("lw2_rdata", rspRdata, 32'hCAFEF00D);
    checkOutput("lw2_err", 32'(rspErr), 32'd0);
    finishRsp("lw2");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
